// File: rtl/bch_eras_chien_2x_if.sv
// Locator-pair input and position-flag output bundle for the dual Chien search.
interface bch_eras_chien_2x_if #(
  parameter int M     = 4,
  parameter int T     = 3,
  parameter int N     = 15,
  parameter int PTR_W = 2
);
  localparam int IDX_W = $clog2(N);
  localparam int NUM_W = $clog2(T + 1) + 1;

  logic                 iloc_poly_val;
  logic [PTR_W-1:0]     iloc_poly_ptr;
  logic [M-1:0]         iloc_poly [2][0:T];

  logic                 ordy;
  logic                 oval;
  logic                 osop;
  logic                 oeop;
  logic [IDX_W-1:0]     oidx;
  logic [1:0]           oerr;
  logic [PTR_W-1:0]     optr;
  logic [NUM_W-1:0]     oerr_num [2];
  logic [1:0]           odecfail;
  logic                 osel;

  modport master (
    output iloc_poly_val, iloc_poly_ptr, iloc_poly,
    input  ordy, oval, osop, oeop, oidx, oerr, optr, oerr_num, odecfail, osel
  );

  modport slave (
    input  iloc_poly_val, iloc_poly_ptr, iloc_poly,
    output ordy, oval, osop, oeop, oidx, oerr, optr, oerr_num, odecfail, osel
  );
endinterface

// File: rtl/bch_eras_chien_2x.sv
// Dual Chien search for the binary BCH erasure decoder.
// Evaluates the zero-filled (0) and one-filled (1) locators at every position,
// one position per clock from n-1 down to 0, and reports root counts/failure.
// Optional feature macro: BCH_ERAS_CHIEN_SEL_EN (drives osel with the preferred
// locator; without it osel is tied 0).
//
// state        | meaning
// cRESET_STATE | leaving reset, ordy low
// cWAIT_STATE  | idle, ordy high, latch pair on iloc_poly_val
// cINIT_STATE  | scale coefficients to the first position, emit idx n-1
// cSCAN_STATE  | stream flags idx n-1..0, back to wait after idx 0
module bch_eras_chien_2x #(
  parameter int M      = 4,
  parameter int D      = 7,
  parameter int N      = 15,
  parameter int IRRPOL = 19,
  parameter int PTR_W  = 2
) (
  input  logic iclk,
  input  logic ireset,
  input  logic iclkena,
  bch_eras_chien_2x_if.slave bus
);
  localparam int T     = (D - 1) / 2;
  localparam int IDX_W = $clog2(N);
  localparam int NUM_W = $clog2(T + 1) + 1;
  localparam int Q     = (1 << M) - 1;
  localparam int S     = Q - (N - 1);
  localparam logic [M-1:0]     POLY     = IRRPOL[M-1:0];
  localparam logic [NUM_W-1:0] NUM_MAX  = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] acc;
    logic [M-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? POLY : '0);
    end
    return acc;
  endfunction

  // alpha^e; only ever called with elaboration constants, so every product
  // against it reduces to a fixed XOR network
  function automatic logic [M-1:0] gf_alpha_pow(input int e);
    logic [M-1:0] p;
    p = {{(M-1){1'b0}}, 1'b1};
    for (int i = 0; i < Q; i++)
      if (i < e) p = gf_mul(p, {{(M-2){1'b0}}, 2'b10});
    return p;
  endfunction

  typedef enum logic [1:0] {cRESET_STATE, cWAIT_STATE, cINIT_STATE, cSCAN_STATE} state_t;
  state_t state_q, state_d;

  logic [M-1:0]     lam_q [2][0:T];
  logic [M-1:0]     r_q   [2][0:T];
  logic [M-1:0]     r_src [2][0:T];
  logic [M-1:0]     r_nxt [2][0:T];
  logic [M-1:0]     syn   [2];
  logic [NUM_W-1:0] deg_q [2], deg_in [2];
  logic [NUM_W-1:0] cnt_q [2], cnt_base [2], cnt_d [2], num_q [2];
  logic [1:0]       all_zero_q, all_zero_in, root, fail_d, decfail_q, oerr_q;
  logic [PTR_W-1:0] ptr_q;
  logic             oval_q, osop_q, oeop_q;
  logic [IDX_W-1:0] oidx_q;

  // state register
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset)      state_q <= cRESET_STATE;
    else if (iclkena) state_q <= state_d;
  end

  // next-state; oidx_q doubles as the scan down-counter, 0 is terminal
  always_comb begin
    state_d = state_q;
    case (state_q)
      cRESET_STATE: state_d = cWAIT_STATE;
      cWAIT_STATE:  if (bus.iloc_poly_val) state_d = cINIT_STATE;
      cINIT_STATE:  state_d = cSCAN_STATE;
      cSCAN_STATE:  if (oidx_q == '0) state_d = cWAIT_STATE;
      default:      state_d = cRESET_STATE;
    endcase
  end

  // per-position evaluation, root counting and incoming degree detection
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      syn[k]         = '0;
      deg_in[k]      = '0;
      all_zero_in[k] = 1'b1;
      for (int j = 0; j <= T; j++) begin
        r_src[k][j] = (state_q == cINIT_STATE) ?
                      gf_mul(lam_q[k][j], gf_alpha_pow((j * S) % Q)) : r_q[k][j];
        r_nxt[k][j] = gf_mul(r_src[k][j], gf_alpha_pow(j));
        syn[k]      = syn[k] ^ r_src[k][j];
        if (bus.iloc_poly[k][j] != '0) begin
          deg_in[k]      = NUM_W'(j);
          all_zero_in[k] = 1'b0;
        end
      end
      root[k]     = (syn[k] == '0);
      cnt_base[k] = (state_q == cINIT_STATE) ? '0 : cnt_q[k];
      cnt_d[k]    = (cnt_base[k] == NUM_MAX) ? cnt_base[k] : cnt_base[k] + NUM_W'(root[k]);
      fail_d[k]   = all_zero_q[k] | (cnt_d[k] != deg_q[k]);
    end
  end

  // datapath and registered output stream; everything holds while iclkena is low
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j <= T; j++) begin
          lam_q[k][j] <= '0;
          r_q[k][j]   <= '0;
        end
        deg_q[k] <= '0;
        cnt_q[k] <= '0;
        num_q[k] <= '0;
      end
      all_zero_q <= '0;
      decfail_q  <= '0;
      oerr_q     <= '0;
      ptr_q      <= '0;
      oval_q     <= 1'b0;
      osop_q     <= 1'b0;
      oeop_q     <= 1'b0;
      oidx_q     <= '0;
    end else if (iclkena) begin
      case (state_q)
        cWAIT_STATE: if (bus.iloc_poly_val) begin
          lam_q      <= bus.iloc_poly;
          ptr_q      <= bus.iloc_poly_ptr;
          deg_q      <= deg_in;
          all_zero_q <= all_zero_in;
        end
        cINIT_STATE: begin
          r_q    <= r_nxt;
          cnt_q  <= cnt_d;
          oerr_q <= root;
          oval_q <= 1'b1;
          osop_q <= 1'b1;
          oeop_q <= 1'b0;
          oidx_q <= IDX_LAST;
        end
        cSCAN_STATE: begin
          osop_q <= 1'b0;
          if (oidx_q == '0) begin
            oval_q <= 1'b0;
            oeop_q <= 1'b0;
            oerr_q <= '0;
          end else begin
            r_q    <= r_nxt;
            cnt_q  <= cnt_d;
            oerr_q <= root;
            oidx_q <= oidx_q - IDX_ONE;
            oeop_q <= (oidx_q == IDX_ONE);
            if (oidx_q == IDX_ONE) begin
              num_q     <= cnt_d;
              decfail_q <= fail_d;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BCH_ERAS_CHIEN_SEL_EN
  logic sel_d, sel_q;

  // prefer the passing locator; both passing -> fewer roots, ties to 0
  always_comb begin
    sel_d = 1'b0;
    if (!fail_d[0] && !fail_d[1]) sel_d = (cnt_d[1] < cnt_d[0]);
    else if (fail_d[0] && !fail_d[1]) sel_d = 1'b1;
  end

  // selection is captured alongside the last position
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) sel_q <= 1'b0;
    else if (iclkena && state_q == cSCAN_STATE && oidx_q == IDX_ONE) sel_q <= sel_d;
  end

  assign bus.osel = sel_q;
`else
  assign bus.osel = 1'b0;
`endif

  assign bus.ordy     = (state_q == cWAIT_STATE);
  assign bus.oval     = oval_q;
  assign bus.osop     = osop_q;
  assign bus.oeop     = oeop_q;
  assign bus.oidx     = oidx_q;
  assign bus.oerr     = oerr_q;
  assign bus.optr     = ptr_q;
  assign bus.oerr_num = num_q;
  assign bus.odecfail = decfail_q;
endmodule

// File: tb/tb_bch_eras_chien_2x.sv
// Directed bench for bch_eras_chien_2x (m=4, n=15, t=3, irrpol=19).
module tb_bch_eras_chien_2x;
  localparam int M = 4, T = 3, N = 15, PTR_W = 2;
`ifdef BCH_ERAS_CHIEN_SEL_EN
  localparam bit SEL_ON = 1'b1;
`else
  localparam bit SEL_ON = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, clkena = 1'b1;
  always #5 clk = ~clk;

  bch_eras_chien_2x_if #(.M(M), .T(T), .N(N), .PTR_W(PTR_W)) bus ();

  bch_eras_chien_2x #(.M(M), .D(7), .N(N), .IRRPOL(19), .PTR_W(PTR_W)) dut (
    .iclk(clk), .ireset(rst_n), .iclkena(clkena), .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // returns at cycle A+2 (first flag cycle)
  task automatic start_frame(input string name, input logic [15:0] p0, input logic [15:0] p1,
                             input logic [1:0] ptr);
    int w;
    w = 0;
    while (bus.ordy !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    chk({name, ".ordy_wait"}, 32'(bus.ordy), 32'd1);
    for (int j = 0; j <= T; j++) begin
      bus.iloc_poly[0][j] = p0[4*j +: 4];
      bus.iloc_poly[1][j] = p1[4*j +: 4];
    end
    bus.iloc_poly_ptr = ptr;
    bus.iloc_poly_val = 1'b1;
    tick();
    bus.iloc_poly_val = 1'b0;
    chk({name, ".ordy_drop"}, 32'(bus.ordy), 32'd0);
    tick();
  endtask

  task automatic run_frame(input string name, input logic [15:0] p0, input logic [15:0] p1,
                           input logic [1:0] ptr, input logic [14:0] e0, input logic [14:0] e1,
                           input int n0, input int n1, input logic [1:0] df, input logic sel,
                           input bit stall, input bit dup);
    logic [14:0] g0, g1;
    int nval;
    bit idx_ok, eop_ok;
    g0 = '0; g1 = '0; nval = 0; idx_ok = 1'b1; eop_ok = 1'b1;
    start_frame(name, p0, p1, ptr);
    chk({name, ".sop"}, 32'(bus.osop), 32'd1);
    chk({name, ".idx_first"}, 32'(bus.oidx), 32'd14);
    for (int i = 0; i < N; i++) begin
      if (bus.oval === 1'b1) begin
        nval++;
        g0[bus.oidx] = bus.oerr[0];
        g1[bus.oidx] = bus.oerr[1];
      end
      if (bus.oidx !== 4'(N - 1 - i)) idx_ok = 1'b0;
      if (bus.oeop !== (i == N - 1)) eop_ok = 1'b0;
      if (i == N - 1) begin
        chk({name, ".num0"}, 32'(bus.oerr_num[0]), 32'(n0));
        chk({name, ".num1"}, 32'(bus.oerr_num[1]), 32'(n1));
        chk({name, ".decfail"}, 32'(bus.odecfail), 32'(df));
        chk({name, ".sel"}, 32'(bus.osel), 32'(SEL_ON & sel));
        chk({name, ".ptr"}, 32'(bus.optr), 32'(ptr));
      end
      if (stall && i == 5) begin
        clkena = 1'b0;
        repeat (3) tick();
        chk({name, ".stall_oval"}, 32'(bus.oval), 32'd1);
        chk({name, ".stall_idx"}, 32'(bus.oidx), 32'd9);
        clkena = 1'b1;
      end
      if (dup && i == 3) bus.iloc_poly_val = 1'b1;
      if (dup && i == 4) bus.iloc_poly_val = 1'b0;
      tick();
    end
    chk({name, ".nval"}, 32'(nval), 32'd15);
    chk({name, ".idx_seq"}, 32'(idx_ok), 32'd1);
    chk({name, ".eop_pos"}, 32'(eop_ok), 32'd1);
    chk({name, ".err0"}, 32'(g0), 32'(e0));
    chk({name, ".err1"}, 32'(g1), 32'(e1));
    chk({name, ".oval_end"}, 32'(bus.oval), 32'd0);
    chk({name, ".ordy_back"}, 32'(bus.ordy), 32'd1);
    if (dup) begin
      repeat (3) tick();
      chk({name, ".dup_idle"}, 32'(bus.oval), 32'd0);
    end
  endtask

  initial begin
    bus.iloc_poly_val = 1'b0;
    bus.iloc_poly_ptr = '0;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j <= T; j++) bus.iloc_poly[k][j] = '0;

    // reset values
    repeat (2) tick();
    chk("rst.ordy", 32'(bus.ordy), 32'd0);
    chk("rst.oval", 32'(bus.oval), 32'd0);
    chk("rst.osop", 32'(bus.osop), 32'd0);
    chk("rst.oeop", 32'(bus.oeop), 32'd0);
    chk("rst.oidx", 32'(bus.oidx), 32'd0);
    chk("rst.oerr", 32'(bus.oerr), 32'd0);
    chk("rst.odecfail", 32'(bus.odecfail), 32'd0);
    chk("rst.osel", 32'(bus.osel), 32'd0);
    chk("rst.num0", 32'(bus.oerr_num[0]), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst.ordy_first", 32'(bus.ordy), 32'd1);

    // Lambda = 1 for both: no roots, both pass
    run_frame("f1", 16'h0001, 16'h0001, 2'd1, 15'h0000, 15'h0000, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    // L0 = 1 + a^3 x (root 3), L1 = 1 + a^12 x + a^9 x^2 (roots 7,2); stall mid-frame
    run_frame("f2", 16'h0081, 16'h0AF1, 2'd2, 15'h0008, 15'h0084, 1, 2, 2'b00, 1'b0, 1'b1, 1'b0);
    // L0 all zero: every position flagged, count saturates, fails -> sel 1
    run_frame("f3", 16'h0000, 16'h0AF1, 2'd3, 15'h7FFF, 15'h0084, 7, 2, 2'b01, 1'b1, 1'b0, 1'b0);
    // L0 = 1 + x (root at idx 0), L1 = a^3 + x + x^2 irreducible; extra val pulse at A+5
    run_frame("f4", 16'h0011, 16'h0118, 2'd0, 15'h0001, 15'h0000, 1, 0, 2'b10, 1'b0, 1'b0, 1'b1);

    // reset mid-scan at A+8
    start_frame("ab", 16'h0081, 16'h0001, 2'd1);
    repeat (6) tick();
    chk("ab.pre_oval", 32'(bus.oval), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ab.oval", 32'(bus.oval), 32'd0);
    chk("ab.ordy", 32'(bus.ordy), 32'd0);
    chk("ab.oeop", 32'(bus.oeop), 32'd0);
    chk("ab.optr", 32'(bus.optr), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("ab.ordy_after", 32'(bus.ordy), 32'd1);
    chk("ab.oval_after", 32'(bus.oval), 32'd0);

    // both pass, L1 has fewer roots -> sel 1
    run_frame("f5", 16'h0AF1, 16'h0081, 2'd2, 15'h0084, 15'h0008, 2, 1, 2'b00, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/bch_eras_chien_2x.md
# bch_eras_chien_2x

Dual Chien search for the binary BCH erasure decoder. It consumes the pair of error-locator polynomials produced by the erasure Berlekamp stage: index 0 is the "erasures filled with 0" decode and index 1 is the "erasures filled with 1" decode. It evaluates both polynomials at every codeword position, one position per clock, and streams per-position error flags to the correction buffer. At end of frame it reports root counts and decoding-failure status for each polynomial.

## Interface
- m, 4, GF(2^m) field width; data_t is m bits.
- k_max, 5, max data length; used only by the shared parameter include.
- d, 7, code distance; t = (d-1)/2, t2 = 2t.
- n, 15, codeword length; n ≤ 2^m-1.
- irrpol, 19, field primitive polynomial.
- iclk  in  1  clock.
- ireset  in  1  asynchronous reset, active-low (0 = reset).
- iclkena  in  1  clock enable; when low, all state and outputs hold.
- iloc_poly_val  in  1  locator pair valid; accepted only while ordy=1.
- iloc_poly_ptr  in  ptr_t  frame buffer pointer tagging the pair.
- iloc_poly  in  data_t [2][0:t]  locator coefficients; [j] is the coefficient of x^j.
- ordy  out  1  block idle, can accept a pair.
- oval  out  1  position flag valid.
- osop  out  1  first position of frame (idx n-1).
- oeop  out  1  last position of frame (idx 0).
- oidx  out  $clog2(n)  codeword position being reported.
- oerr  out  2  oerr[k]=1: position oidx is a root of polynomial k.
- optr  out  ptr_t  latched pointer; constant for the whole frame.
- oerr_num  out  [2][cNUM_W]  root count per polynomial; valid with oeop. cNUM_W = $clog2(t+1)+1.
- odecfail  out  2  failure per polynomial; valid with oeop.
- osel  out  1  preferred polynomial index; valid with oeop (see Configuration).

## Operation
- FSM states and transitions:
  - cRESET_STATE → cWAIT_STATE.
  - cWAIT_STATE (ordy=1) → cINIT_STATE when iloc_poly_val=1.
  - cINIT_STATE → cSCAN_STATE.
  - cSCAN_STATE stays for n cycles, then → cWAIT_STATE.
- cWAIT_STATE accept:
  - latch iloc_poly_ptr.
  - compute degree deg[k] = highest j with nonzero coefficient; 0 if only [0] is nonzero.
  - flag the all-zero polynomial.
- cINIT_STATE: r[k][j] <= Λk[j]·α^(j·(2^m-1-(n-1)) mod (2^m-1)). Constant multipliers are built from irrpol via gf functions.
- cSCAN_STATE, each cycle:
  - root[k] = (XOR over j of r[k][j]) == 0.
  - r[k][j] <= r[k][j]·α^j, using constant multipliers with no general multiplier.
  - Emit oidx from n-1 down to 0.
- Root counters saturate at 2^cNUM_W-1; all-zero polynomials saturate on the first cycles.
- odecfail[k] = all_zero[k] | (count[k] != deg[k]).
- iloc_poly_val while ordy=0: ignored, no queue. The upstream stage holds val until ordy.
- Arithmetic is GF(2): addition is XOR, and every product is reduced by irrpol.

## Timing
- Reset values: ordy=0 during reset and 1 from the first enabled cycle after cRESET_STATE. All other outputs are 0.
- Accept at cycle A (cWAIT_STATE & iloc_poly_val & iclkena):
  - oval/osop at A+2 with oidx=n-1.
  - oeop at A+n+1 with oidx=0, together with oerr_num/odecfail/osel.
- ordy=0 from A+1 through A+n+1; it is 1 again at A+n+2. Back-to-back throughput is n+2 cycles per frame.
- oval is contiguous for n cycles; oerr is registered and aligned with oidx.
- Reset mid-scan: immediate abort, no oeop, outputs to reset values, new frame accepted after cRESET_STATE.
- iclkena low mid-scan: stream stalls, and oval stays asserted (held) while iclkena=0.

## Configuration
- BCH_ERAS_CHIEN_SEL_EN defined:
  - osel chooses the polynomial with odecfail=0.
  - If both pass, osel picks the smaller oerr_num; ties go to 0.
  - If both fail, osel=0.
- Not defined: osel tied 0 and the selection logic is removed. Other behaviour is identical.

## Test plan
All scenarios use m=4, n=15, d=7 (t=3), irrpol=19.
- Λ0=Λ1={1,0,0,0} → no oerr bits over 15 positions; oerr_num={0,0}, odecfail=00.
- Λ0={1,α^3,0,0} → oerr[0]=1 only at oidx=3; oerr_num[0]=1, odecfail[0]=0.
- Λ1={1,α^12,α^9,0} (roots at positions 2, 7) → oerr[1] at oidx 7 and 2; oerr_num[1]=2, odecfail[1]=0. With SEL_EN, Λ0 from the previous scenario gives osel=0 (1<2).
- Λ0 all zero → oerr[0]=1 on all positions; oerr_num[0] saturates; odecfail[0]=1. With SEL_EN and Λ1 valid, osel=1.
- Second iloc_poly_val pulse at A+5 → ignored; exactly one frame of 15 oval, ordy returns at A+17.
- ireset low at A+8 → oval/ordy drop asynchronously; no oeop; next pair accepted normally after release.
